ycbcr_stream_ctrl: RTL and testbench

YCBCR_STREAM_CTRL -- requirements
Module: ycbcr_stream_ctrl

---
 rtl/ycbcr_stream_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ycbcr_stream_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_stream_ctrl.sv
// RGB->YCbCr stream controller: frame FSM, credit-based input throttle around an
// external fixed-latency converter, output FIFO with frame markers. Option: YCBCR_CTRL_ABORT_EN adds iAbort.
module ycbcr_stream_ctrl #(
  parameter int LATENCY    = 3,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  output logic       oBusy,
  output logic       oDone,
`ifdef YCBCR_CTRL_ABORT_EN
  input  logic       iAbort,
`endif
  input  logic       iValid,
  output logic       oReady,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  output logic       oCe,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
  input  logic [7:0] iY,
  input  logic [7:0] iCb,
  input  logic [7:0] iCr,
  output logic       oValid,
  input  logic       iReady,
  output logic [7:0] oY,
  output logic [7:0] oCb,
  output logic [7:0] oCr,
  output logic       oSof,
  output logic       oEol,
  output logic       oEof
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int NW    = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(IMG_W + 1);
  localparam int YW    = $clog2(IMG_H + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int IW    = $clog2(LATENCY + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]         state;
  logic [NW-1:0]      inCnt;
  logic [XW-1:0]      ox;
  logic [YW-1:0]      oy;
  logic [LATENCY-1:0] vldPipe, vldNext;
  logic [23:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]      wrPtr, rdPtr;
  logic [CW-1:0]      fifoCnt;
  logic [IW-1:0]      inflight;
  logic               doneR, accept, push, pop, lastIn, lastOut, abortReq;

`ifdef YCBCR_CTRL_ABORT_EN
  assign abortReq = iAbort && (state != IDLE);
`else
  assign abortReq = 1'b0;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + IW'(vldPipe[i]);
  end

  // Credit covers pixels already inside the converter so the FIFO can never overflow.
  assign oReady  = (state == RUN) &&
                   (({1'b0, fifoCnt} + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH));
  assign accept  = iValid && oReady;
  assign oCe     = (state != IDLE);
  assign oBusy   = (state != IDLE);
  assign oDone   = doneR;
  assign {oR, oG, oB} = {iR, iG, iB};

  assign push    = oCe && vldPipe[LATENCY-1];
  assign oValid  = (fifoCnt != '0);
  assign pop     = oValid && iReady;
  assign {oY, oCb, oCr} = oValid ? mem[rdPtr] : 24'd0;

  assign oSof    = oValid && (ox == '0) && (oy == '0);
  assign oEol    = oValid && (ox == XW'(IMG_W - 1));
  assign oEof    = oEol && (oy == YW'(IMG_H - 1));
  assign lastIn  = accept && (inCnt == NW'(TOTAL - 1));
  assign lastOut = pop && oEof && (state == DRAIN);

  generate
    if (LATENCY == 1) begin : gShort
      assign vldNext = accept;
    end else begin : gLong
      assign vldNext = {vldPipe[LATENCY-2:0], accept};
    end
  endgenerate

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state <= IDLE;
      inCnt <= '0;
      ox    <= '0;
      oy    <= '0;
      doneR <= 1'b0;
    end else if (abortReq) begin
      state <= IDLE;
      inCnt <= '0;
      ox    <= '0;
      oy    <= '0;
      doneR <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          state <= RUN;
          inCnt <= '0;
          ox    <= '0;
          oy    <= '0;
        end
        RUN:   if (lastIn) state <= DRAIN;
        DRAIN: if (lastOut) begin
          state <= IDLE;
          doneR <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (accept && inCnt != NW'(TOTAL)) inCnt <= inCnt + NW'(1);
      if (pop) begin
        if (ox == XW'(IMG_W - 1)) begin
          ox <= '0;
          oy <= (oy == YW'(IMG_H - 1)) ? '0 : oy + YW'(1);
        end else begin
          ox <= ox + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      vldPipe <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else if (abortReq) begin
      vldPipe <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (oCe) vldPipe <= vldNext;
      if (push) wrPtr <= bump(wrPtr);
      if (pop)  rdPtr <= bump(rdPtr);
      case ({push, pop})
        2'b10:   fifoCnt <= fifoCnt + CW'(1);
        2'b01:   fifoCnt <= fifoCnt - CW'(1);
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge iClk) begin
    if (push) mem[wrPtr] <= {iY, iCb, iCr};
  end

endmodule

// File: tb/tb_ycbcr_stream_ctrl.sv
// Directed/randomized bench for ycbcr_stream_ctrl: identity converter model plus a
// pixel-queue reference; covers streaming, backpressure, reset mid-drain and optional abort.
module tb_ycbcr_stream_ctrl;
  localparam int LAT = 3, W = 8, H = 4, FD = 8, TOT = W * H;

  logic       iClk = 1'b0, iRst = 1'b0, iStart = 1'b0, iValid = 1'b0, iReady = 1'b0;
  logic [7:0] iR = '0, iG = '0, iB = '0, iY, iCb, iCr;
  logic       oBusy, oDone, oReady, oCe, oValid, oSof, oEol, oEof;
  logic [7:0] oR, oG, oB, oY, oCb, oCr;
`ifdef YCBCR_CTRL_ABORT_EN
  logic       iAbort = 1'b0;
`endif

  always #5 iClk = ~iClk;

  ycbcr_stream_ctrl #(.LATENCY(LAT), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(FD)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
`ifdef YCBCR_CTRL_ABORT_EN
    .iAbort(iAbort),
`endif
    .iValid(iValid), .oReady(oReady), .iR(iR), .iG(iG), .iB(iB),
    .oCe(oCe), .oR(oR), .oG(oG), .oB(oB), .iY(iY), .iCb(iCb), .iCr(iCr),
    .oValid(oValid), .iReady(iReady), .oY(oY), .oCb(oCb), .oCr(oCr),
    .oSof(oSof), .oEol(oEol), .oEof(oEof)
  );

  // Converter stand-in: LAT-stage identity pipeline advancing only while oCe is high.
  logic [23:0] cpipe [LAT];
  always @(posedge iClk) begin
    if (oCe) begin
      for (int i = LAT - 1; i > 0; i--) cpipe[i] <= cpipe[i-1];
      cpipe[0] <= {oR, oG, oB};
    end
  end
  assign {iY, iCb, iCr} = cpipe[LAT-1];

  int          nChecks = 0, nErr = 0;
  int          accN = 0, popN = 0, cycN = 0, firstAcc = -1, firstVld = -1;
  bit          busyExp = 0, doneExp = 0, chk115 = 0;
  logic [23:0] expQ [$];
  logic [23:0] pixArr [TOT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nErr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drivePix();
    {iR, iG, iB} = (accN < TOT) ? pixArr[accN] : 24'd0;
  endtask

  // One clock: observe at the falling edge, update the reference, step past the rising edge.
  task automatic cyc();
    bit acc, pop, startNow;
    @(negedge iClk);
    cycN++;
    chk("oBusy", oBusy, busyExp);
    chk("oCe", oCe, busyExp);
    chk("oDone", oDone, doneExp);
    if (!busyExp) chk("oReadyIdle", oReady, 0);
    acc = iValid && oReady;
    pop = oValid && iReady;
    if (acc) begin
      expQ.push_back(pixArr[accN]);
      accN++;
      if (firstAcc < 0) firstAcc = cycN;
    end
    if (oValid) begin
      if (firstVld < 0) firstVld = cycN;
      chk("validHasData", expQ.size() != 0, 1);
      if (expQ.size() != 0) chk("data", {oY, oCb, oCr}, expQ[0]);
      chk("oSof", oSof, popN == 0);
      chk("oEol", oEol, (popN % W) == W - 1);
      chk("oEof", oEof, popN == TOT - 1);
    end else begin
      chk("markersIdle", {oSof, oEol, oEof}, 0);
    end
    if (pop) begin
      if (chk115 && popN == 5) chk("px115", {oY, oCb, oCr}, 24'h734E62);
      if (expQ.size() != 0) void'(expQ.pop_front());
      popN++;
    end
    startNow = iStart && !busyExp;
    doneExp  = pop && (popN == TOT) && busyExp;
    if (doneExp) busyExp = 0;
    if (startNow) begin
      busyExp = 1; accN = 0; popN = 0; expQ.delete();
    end
`ifdef YCBCR_CTRL_ABORT_EN
    if (iAbort && busyExp && !startNow) begin
      busyExp = 0; doneExp = 0; expQ.delete();
    end
`endif
    @(posedge iClk);
    #1;
    drivePix();
  endtask

  task automatic patPix();
    for (int n = 0; n < TOT; n++) pixArr[n] = {8'(n), 8'(n + 1), 8'(n + 2)};
  endtask

  task automatic startFrame(input logic v, input logic r);
    iStart = 1; iValid = v; iReady = r;
    accN = 0; drivePix();
    cyc();
    iStart = 0;
  endtask

  task automatic runToDone(input string tag);
    int g = 0;
    while (busyExp && g < 2000) begin cyc(); g++; end
    chk({tag, "Timeout"}, g < 2000, 1);
    cyc();  // oDone lands here
    chk({tag, "Count"}, popN, TOT);
    chk({tag, "QEmpty"}, expQ.size(), 0);
  endtask

  task automatic rstChk(input string tag);
    chk({tag, "Ctl"}, {oReady, oValid, oCe, oBusy, oDone, oSof, oEol, oEof}, 0);
    chk({tag, "Data"}, {oY, oCb, oCr}, 0);
  endtask

  initial begin
    int g;
    patPix();
    #2 rstChk("rst0");
    @(negedge iClk) iRst = 1;
    @(posedge iClk); #1;
    repeat (2) cyc();

    // Scenario 1: continuous stream, sink always ready
    firstAcc = -1; firstVld = -1; cycN = 0;
    startFrame(1, 1);
    runToDone("s1");
    chk("s1Latency", firstVld - firstAcc, LAT + 1);
    repeat (2) cyc();

    // Scenario 2: sink stalled, credit limit then release
    startFrame(1, 0);
    repeat (20) cyc();
    chk("s2Accepts", accN, FD);
    chk("s2Ready", oReady, 0);
    chk("s2Held", expQ.size(), FD);
    iReady = 1;
    runToDone("s2");

    // Scenario 3: random valid, toggling ready, random data
    for (int n = 0; n < TOT; n++) pixArr[n] = 24'($urandom);
    pixArr[5] = {8'd115, 8'd78, 8'd98};
    chk115 = 1;
    startFrame(1, 0);
    g = 0;
    while (busyExp && g < 2000) begin
      iValid = 1'($urandom_range(0, 1));
      iReady = ~iReady;
      cyc(); g++;
    end
    chk("s3Timeout", g < 2000, 1);
    iReady = 1;
    cyc();
    chk("s3Count", popN, TOT);
    chk115 = 0;

    // Scenario 4: reset while draining
    patPix();
    startFrame(1, 1);
    g = 0;
    while (accN < TOT && g < 500) begin cyc(); g++; end
    chk("s4Timeout", g < 500, 1);
    iReady = 0;
    repeat (2) cyc();
    chk("s4Busy", oBusy, 1);
    chk("s4Valid", oValid, 1);
    #2 iRst = 0;
    #1 rstChk("s4Rst");
    busyExp = 0; doneExp = 0; expQ.delete();
    @(negedge iClk) iRst = 1;
    @(posedge iClk); #1;
    repeat (3) cyc();
    startFrame(1, 1);
    runToDone("s4");

`ifdef YCBCR_CTRL_ABORT_EN
    // Scenario 5: abort mid-frame, then a full frame
    startFrame(1, 1);
    g = 0;
    while (accN < 10 && g < 100) begin cyc(); g++; end
    chk("s5Timeout", g < 100, 1);
    iAbort = 1;
    cyc();
    iAbort = 0;
    chk("s5Busy", oBusy, 0);
    chk("s5Valid", oValid, 0);
    chk("s5Done", oDone, 0);
    repeat (3) cyc();
    startFrame(1, 1);
    runToDone("s5");
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end

endmodule
